stream_clear_sequencer: RTL and testbench



---
 rtl/stream_clear_seq_pkg.sv | 24 ++
 rtl/stream_clear_sequencer.sv | 152 +++++++++++++++
 tb/tb_stream_clear_sequencer.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_clear_seq_pkg.sv
// Shared types for stream_clear_sequencer: FSM state encoding and the
// saturating increment used by the drop counter.
package stream_clear_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    CLEAR,
    WAIT_HI,
    WAIT_LO,
    REMOTE
  } state_e;

  localparam int unsigned SatW = 32;

  // Widths above SatW are not supported; counters are zero-extended into SatW.
  function automatic logic [SatW-1:0] sat_inc(input logic [SatW-1:0] val,
                                              input int unsigned    width);
    logic [SatW-1:0] max_val;
    max_val = (width >= SatW) ? '1 : ((SatW'(1) << width) - SatW'(1));
    sat_inc = (val >= max_val) ? max_val : val + SatW'(1);
  endfunction

endpackage

// File: rtl/stream_clear_sequencer.sv
// Source-side front-end for the clearable CDC FIFO: one-entry output stage plus
// clear sequencing. Optional FLUSH timeout enabled by STREAM_CLEAR_SEQ_TIMEOUT_EN.
module stream_clear_sequencer
  import stream_clear_seq_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter type         T            = logic [WIDTH-1:0],
  parameter int unsigned CntWidth     = 8,
  parameter int unsigned FlushTimeout = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_req_i,
  output logic                clear_busy_o,
  output logic                clear_done_o,
  output logic [CntWidth-1:0] drop_cnt_o,
  input  T                    slv_data_i,
  input  logic                slv_valid_i,
  output logic                slv_ready_o,
  output T                    mst_data_o,
  output logic                mst_valid_o,
  input  logic                mst_ready_i,
  output logic                cdc_clear_o,
  input  logic                cdc_clear_pending_i,
  output state_e              dbg_state_o
);

  if (FlushTimeout < 1) begin : g_bad_timeout
    $error("FlushTimeout must be >= 1");
  end

  // Handshakes: a beat moves when valid && ready are both high at a rising edge;
  // valid never drops without that transfer except when a clear drops the beat.

  state_e              state_q, state_d;
  T                    data_q, data_d;
  logic                valid_q, valid_d;
  logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                done_q, done_d;
  logic                slv_ready;
  logic                drop;

`ifdef STREAM_CLEAR_SEQ_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(FlushTimeout + 1);
  logic [TmrW-1:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    drop_cnt_d = drop_cnt_q;
    done_d     = 1'b0;
    slv_ready  = 1'b0;
    drop       = 1'b0;
`ifdef STREAM_CLEAR_SEQ_TIMEOUT_EN
    timer_d    = timer_q;
`endif

    unique case (state_q)
      IDLE: begin
        slv_ready = !valid_q || mst_ready_i;
        if (valid_q && mst_ready_i) valid_d = 1'b0;
        if (slv_valid_i && slv_ready) begin
          data_d  = slv_data_i;
          valid_d = 1'b1;
        end
        // A remote clear wins; whatever the stage holds after this edge is lost.
        if (cdc_clear_pending_i) begin
          state_d = REMOTE;
          if (valid_d) begin
            drop    = 1'b1;
            valid_d = 1'b0;
          end
        end else if (clear_req_i) begin
          state_d = FLUSH;
`ifdef STREAM_CLEAR_SEQ_TIMEOUT_EN
          timer_d = TmrW'(FlushTimeout);
`endif
        end
      end
      FLUSH: begin
        if (cdc_clear_pending_i) begin
          if (valid_q && !mst_ready_i) drop = 1'b1;
          valid_d = 1'b0;
          state_d = WAIT_LO;
        end else if (!valid_q || mst_ready_i) begin
          valid_d = 1'b0;
          state_d = CLEAR;
        end
`ifdef STREAM_CLEAR_SEQ_TIMEOUT_EN
        else if (timer_q == TmrW'(1)) begin
          drop    = 1'b1;
          valid_d = 1'b0;
          state_d = CLEAR;
        end else begin
          timer_d = timer_q - TmrW'(1);
        end
`endif
      end
      CLEAR: begin
        valid_d = 1'b0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (cdc_clear_pending_i) state_d = WAIT_LO;
      end
      WAIT_LO, REMOTE: begin
        valid_d = 1'b0;
        if (!cdc_clear_pending_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop) drop_cnt_d = CntWidth'(sat_inc(SatW'(drop_cnt_q), CntWidth));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      drop_cnt_q <= '0;
      done_q     <= 1'b0;
`ifdef STREAM_CLEAR_SEQ_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      drop_cnt_q <= drop_cnt_d;
      done_q     <= done_d;
`ifdef STREAM_CLEAR_SEQ_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign slv_ready_o  = slv_ready && rst_ni;
  assign mst_data_o   = data_q;
  assign mst_valid_o  = valid_q;
  assign cdc_clear_o  = (state_q == CLEAR);
  assign clear_busy_o = (state_q != IDLE);
  assign clear_done_o = done_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_stream_clear_sequencer.sv
// Self-checking bench for stream_clear_sequencer: streaming, local and remote
// clears, drop counter saturation, and reset during a sequence.
module tb_stream_clear_sequencer;
  import stream_clear_seq_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 2;
  localparam int unsigned FT = 4;
  localparam logic [CW-1:0] CNT_MAX = 2'd3;

  logic          clk, rst_ni, clear_req_i, clear_busy_o, clear_done_o;
  logic [CW-1:0] drop_cnt_o;
  logic [W-1:0]  slv_data_i, mst_data_o;
  logic          slv_valid_i, slv_ready_o, mst_valid_o, mst_ready_i;
  logic          cdc_clear_o, cdc_clear_pending_i;
  state_e        dbg_state_o;

  int errors = 0;
  int checks = 0;
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_drop = '0;

  stream_clear_sequencer #(
    .WIDTH(W), .CntWidth(CW), .FlushTimeout(FT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_req_i(clear_req_i),
    .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o), .drop_cnt_o(drop_cnt_o),
    .slv_data_i(slv_data_i), .slv_valid_i(slv_valid_i), .slv_ready_o(slv_ready_o),
    .mst_data_o(mst_data_o), .mst_valid_o(mst_valid_o), .mst_ready_i(mst_ready_i),
    .cdc_clear_o(cdc_clear_o), .cdc_clear_pending_i(cdc_clear_pending_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_ni && mst_valid_o && mst_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got %0h want none", mst_data_o);
      end else begin
        logic [W-1:0] exp;
        exp = exp_q.pop_front();
        if (mst_data_o !== exp) begin
          errors++;
          $display("FAIL sb_data: got %0h want %0h", mst_data_o, exp);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_drop();
    exp_drop = (exp_drop == CNT_MAX) ? CNT_MAX : exp_drop + 1'b1;
  endtask

  task automatic pend_pulse(input int n);
    cdc_clear_pending_i = 1'b1;
    repeat (n) step();
    cdc_clear_pending_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; clear_req_i = 1'b0; slv_valid_i = 1'b0; slv_data_i = '0;
    mst_ready_i = 1'b0; cdc_clear_pending_i = 1'b0;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if ({clear_busy_o, clear_done_o, cdc_clear_o, mst_valid_o, slv_ready_o} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b want 00000",
               {clear_busy_o, clear_done_o, cdc_clear_o, mst_valid_o, slv_ready_o});
    end
    checks++;
    if (drop_cnt_o !== '0 || mst_data_o !== '0 || dbg_state_o !== IDLE) begin
      errors++;
      $display("FAIL rst_regs: got cnt=%0d data=%0h st=%0d want 0 0 0",
               drop_cnt_o, mst_data_o, dbg_state_o);
    end
    rst_ni = 1'b1;
    exp_drop = '0;
    step();
    @(negedge clk);
    checks++;
    if (slv_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after: got %b want 1", slv_ready_o);
    end
    step();
  endtask

  task automatic test_stream();
    logic [W-1:0] last;
    last = '0;
    mst_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      slv_valid_i = 1'b1;
      slv_data_i  = W'($urandom);
      @(negedge clk);
      checks++;
      if (slv_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready: got %b want 1", slv_ready_o);
      end else exp_q.push_back(slv_data_i);
      last = slv_data_i;
      step();
    end
    slv_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (mst_valid_o !== 1'b1 || mst_data_o !== last) begin
      errors++;
      $display("FAIL stream_latency: got v=%b d=%0h want v=1 d=%0h", mst_valid_o, mst_data_o, last);
    end
    step();
    @(negedge clk);
    checks++;
    if (mst_valid_o !== 1'b0 || exp_q.size() != 0 || drop_cnt_o !== exp_drop) begin
      errors++;
      $display("FAIL stream_end: got v=%b q=%0d cnt=%0d want 0 0 %0d",
               mst_valid_o, exp_q.size(), drop_cnt_o, exp_drop);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic pv, pr;
    logic [W-1:0] pd;
    pv = 1'b0; pr = 1'b1; pd = '0;
    for (int i = 0; i < 60; i++) begin
      slv_valid_i = 1'($urandom_range(0, 1));
      slv_data_i  = W'($urandom);
      mst_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pv && !pr) begin
        checks++;
        if (mst_valid_o !== 1'b1 || mst_data_o !== pd) begin
          errors++;
          $display("FAIL b2b_hold: got v=%b d=%0h want v=1 d=%0h", mst_valid_o, mst_data_o, pd);
        end
      end
      checks++;
      if (slv_ready_o !== (!mst_valid_o || mst_ready_i)) begin
        errors++;
        $display("FAIL b2b_ready: got %b want %b", slv_ready_o, (!mst_valid_o || mst_ready_i));
      end
      if (slv_valid_i && slv_ready_o) exp_q.push_back(slv_data_i);
      pv = mst_valid_o; pr = mst_ready_i; pd = mst_data_o;
      step();
    end
    slv_valid_i = 1'b0;
    mst_ready_i = 1'b1;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || mst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got q=%0d v=%b want 0 0", exp_q.size(), mst_valid_o);
    end
    step();
  endtask

  task automatic test_local_clear();
    int clr_seen;
    clr_seen = 0;
    mst_ready_i = 1'b0;
    slv_valid_i = 1'b1;
    slv_data_i  = W'($urandom);
    @(negedge clk);
    checks++;
    if (slv_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL lc_load: got %b want 1", slv_ready_o);
    end else exp_q.push_back(slv_data_i);
    step();
    slv_valid_i = 1'b0;
    clear_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({mst_valid_o, clear_busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL lc_idle_full: got %b want 10", {mst_valid_o, clear_busy_o});
    end
    step();
    clear_req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mst_ready_i = 1'b1;
      @(negedge clk);
      if (cdc_clear_o) clr_seen++;
      checks++;
      if ({clear_busy_o, slv_ready_o, mst_valid_o, cdc_clear_o} !== 4'b1010) begin
        errors++;
        $display("FAIL lc_flush: got %b want 1010",
                 {clear_busy_o, slv_ready_o, mst_valid_o, cdc_clear_o});
      end
      step();
    end
    mst_ready_i = 1'b0;
    @(negedge clk);
    if (cdc_clear_o) clr_seen++;
    checks++;
    if ({cdc_clear_o, mst_valid_o, clear_busy_o} !== 3'b101 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL lc_clear: got %b q=%0d want 101 q=0",
               {cdc_clear_o, mst_valid_o, clear_busy_o}, exp_q.size());
    end
    step();
    cdc_clear_pending_i = 1'b1;
    @(negedge clk);
    if (cdc_clear_o) clr_seen++;
    step();
    @(negedge clk);
    if (cdc_clear_o) clr_seen++;
    step();
    cdc_clear_pending_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({clear_done_o, clear_busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL lc_wait_lo: got %b want 01", {clear_done_o, clear_busy_o});
    end
    step();
    @(negedge clk);
    checks++;
    if ({clear_done_o, clear_busy_o} !== 2'b10 || drop_cnt_o !== exp_drop) begin
      errors++;
      $display("FAIL lc_done: got %b cnt=%0d want 10 cnt=%0d",
               {clear_done_o, clear_busy_o}, drop_cnt_o, exp_drop);
    end
    step();
    @(negedge clk);
    checks++;
    if (clear_done_o !== 1'b0 || clr_seen != 1) begin
      errors++;
      $display("FAIL lc_pulses: got done=%b clr=%0d want 0 1", clear_done_o, clr_seen);
    end
    step();
  endtask

`ifdef STREAM_CLEAR_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int flush_cycles;
    flush_cycles = 0;
    mst_ready_i = 1'b0;
    slv_valid_i = 1'b1;
    slv_data_i  = W'($urandom);
    step();
    slv_valid_i = 1'b0;
    clear_req_i = 1'b1;
    step();
    clear_req_i = 1'b0;
    @(negedge clk);
    while (dbg_state_o == FLUSH && flush_cycles < 20) begin
      flush_cycles++;
      step();
      @(negedge clk);
    end
    bump_drop();
    checks++;
    if (flush_cycles != FT) begin
      errors++;
      $display("FAIL to_cycles: got %0d want %0d", flush_cycles, FT);
    end
    checks++;
    if ({cdc_clear_o, mst_valid_o} !== 2'b10 || drop_cnt_o !== exp_drop) begin
      errors++;
      $display("FAIL to_drop: got %b cnt=%0d want 10 cnt=%0d",
               {cdc_clear_o, mst_valid_o}, drop_cnt_o, exp_drop);
    end
    step();
    pend_pulse(2);
    step();
    @(negedge clk);
    checks++;
    if (clear_done_o !== 1'b1) begin
      errors++;
      $display("FAIL to_done: got %b want 1", clear_done_o);
    end
    step();
  endtask
`endif

  task automatic test_remote();
    mst_ready_i = 1'b0;
    slv_valid_i = 1'b1;
    slv_data_i  = W'($urandom);
    step();
    slv_data_i = W'($urandom);
    cdc_clear_pending_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (slv_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL rem_ready: got %b want 0 (k=%0d)", slv_ready_o, k);
      end
      if (k == 0) bump_drop();
      else begin
        checks++;
        if ({clear_busy_o, mst_valid_o} !== 2'b10 || drop_cnt_o !== exp_drop || dbg_state_o !== REMOTE) begin
          errors++;
          $display("FAIL rem_state: got %b cnt=%0d st=%0d want 10 cnt=%0d st=%0d",
                   {clear_busy_o, mst_valid_o}, drop_cnt_o, dbg_state_o, exp_drop, REMOTE);
        end
      end
      step();
    end
    cdc_clear_pending_i = 1'b0;
    slv_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({clear_done_o, clear_busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL rem_hold: got %b want 01", {clear_done_o, clear_busy_o});
    end
    step();
    @(negedge clk);
    checks++;
    if ({clear_done_o, clear_busy_o} !== 2'b10 || drop_cnt_o !== exp_drop) begin
      errors++;
      $display("FAIL rem_done: got %b cnt=%0d want 10 cnt=%0d",
               {clear_done_o, clear_busy_o}, drop_cnt_o, exp_drop);
    end
    step();
  endtask

  task automatic test_saturation();
    mst_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slv_valid_i = 1'b1;
      slv_data_i  = W'($urandom);
      step();
      slv_valid_i = 1'b0;
      bump_drop();
      pend_pulse(2);
      step();
      @(negedge clk);
      checks++;
      if (drop_cnt_o !== exp_drop || clear_done_o !== 1'b1) begin
        errors++;
        $display("FAIL sat_step: got cnt=%0d done=%b want cnt=%0d done=1",
                 drop_cnt_o, clear_done_o, exp_drop);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (drop_cnt_o !== CNT_MAX) begin
      errors++;
      $display("FAIL sat_max: got %0d want %0d", drop_cnt_o, CNT_MAX);
    end
    step();
  endtask

  task automatic test_simultaneous();
    int clr_seen;
    clr_seen = 0;
    clear_req_i = 1'b1;
    cdc_clear_pending_i = 1'b1;
    step();
    clear_req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cdc_clear_o) clr_seen++;
      checks++;
      if (dbg_state_o !== REMOTE) begin
        errors++;
        $display("FAIL sim_state: got %0d want %0d", dbg_state_o, REMOTE);
      end
      step();
    end
    cdc_clear_pending_i = 1'b0;
    step();
    @(negedge clk);
    if (cdc_clear_o) clr_seen++;
    checks++;
    if (clear_done_o !== 1'b1 || clr_seen != 0 || drop_cnt_o !== exp_drop) begin
      errors++;
      $display("FAIL sim_done: got done=%b clr=%0d cnt=%0d want 1 0 %0d",
               clear_done_o, clr_seen, drop_cnt_o, exp_drop);
    end
    step();
  endtask

  task automatic test_reset_mid_seq();
    clear_req_i = 1'b1;
    step();
    clear_req_i = 1'b0;
    step();
    step();
    cdc_clear_pending_i = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (dbg_state_o !== WAIT_LO) begin
      errors++;
      $display("FAIL rm_setup: got %0d want %0d", dbg_state_o, WAIT_LO);
    end
    step();
    rst_ni = 1'b0;
    @(negedge clk);
    checks++;
    if (slv_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rm_ready_in_reset: got %b want 0", slv_ready_o);
    end
    step();
    rst_ni = 1'b1;
    cdc_clear_pending_i = 1'b0;
    exp_drop = '0;
    @(negedge clk);
    checks++;
    if ({clear_busy_o, clear_done_o, cdc_clear_o, mst_valid_o} !== 4'b0 ||
        drop_cnt_o !== exp_drop || mst_data_o !== '0 || dbg_state_o !== IDLE) begin
      errors++;
      $display("FAIL rm_reset_vals: got %b cnt=%0d d=%0h st=%0d want 0000 0 0 0",
               {clear_busy_o, clear_done_o, cdc_clear_o, mst_valid_o},
               drop_cnt_o, mst_data_o, dbg_state_o);
    end
    step();
    @(negedge clk);
    checks++;
    if (clear_done_o !== 1'b0) begin
      errors++;
      $display("FAIL rm_no_done: got %b want 0", clear_done_o);
    end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_local_clear();
`ifdef STREAM_CLEAR_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_remote();
    test_saturation();
    test_simultaneous();
    test_reset_mid_seq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
